// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes the LA32R integer ALU subset, reads the register
// file combinationally and issues op/operands through a one-entry
// valid/ready slot toward the execute stage.
module alu_issue_stage #(
  parameter int ILLEGAL_AS_NOP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic [4:0]  rf_raddr0,
  output logic [4:0]  rf_raddr1,
  input  logic [31:0] rf_rdata0,
  input  logic [31:0] rf_rdata1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] out_pc,
  output logic        ill
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_SLTU = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SRA  = 5'b10000;
  localparam logic [4:0] OP_LU12 = 5'b10011;
  localparam logic [4:0] OP_PCAU = 5'b10111;

  logic        r_valid;
  logic [4:0]  r_alu_op;
  logic [31:0] r_src0;
  logic [31:0] r_src1;
  logic        r_wb_en;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_pc;
  logic        r_ill;

  logic        w_legal;
  logic [4:0]  w_op;
  logic [31:0] w_src0;
  logic [31:0] w_src1;
  logic        w_wb_en;
  logic        w_accept;
  logic [31:0] w_si12;
  logic [31:0] w_ui12;
  logic [31:0] w_u20;

  assign rf_raddr0 = in_inst[9:5];
  assign rf_raddr1 = in_inst[14:10];

  assign w_si12 = {{20{in_inst[21]}}, in_inst[21:10]};
  assign w_ui12 = {20'b0, in_inst[21:10]};
  assign w_u20  = {in_inst[24:5], 12'b0};

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_wb_en  = w_legal && (in_inst[4:0] != 5'd0);

  // Decode: the reg-reg funct field doubles as the ALU opcode; illegal words
  // collapse to ADD 0+0 so the slot contents stay deterministic.
  always_comb begin
    w_legal = 1'b1;
    w_op    = OP_ADD;
    w_src0  = rf_rdata0;
    w_src1  = rf_rdata1;
    if (in_inst[31:15] inside {17'h00020, 17'h00022, 17'h00024, 17'h00025,
                               17'h00029, 17'h0002A, 17'h0002B, 17'h0002E,
                               17'h0002F, 17'h00030}) begin
      w_op = in_inst[19:15];
    end else if (in_inst[31:15] == 17'h00081) begin
      w_op   = OP_SLL;
      w_src1 = {27'b0, in_inst[14:10]};
    end else if (in_inst[31:15] == 17'h00089) begin
      w_op   = OP_SRL;
      w_src1 = {27'b0, in_inst[14:10]};
    end else if (in_inst[31:15] == 17'h00091) begin
      w_op   = OP_SRA;
      w_src1 = {27'b0, in_inst[14:10]};
    end else if (in_inst[31:22] == 10'h008) begin
      w_op   = OP_SLT;
      w_src1 = w_si12;
    end else if (in_inst[31:22] == 10'h009) begin
      w_op   = OP_SLTU;
      w_src1 = w_si12;
    end else if (in_inst[31:22] == 10'h00A) begin
      w_op   = OP_ADD;
      w_src1 = w_si12;
    end else if (in_inst[31:22] == 10'h00D) begin
      w_op   = OP_AND;
      w_src1 = w_ui12;
    end else if (in_inst[31:22] == 10'h00E) begin
      w_op   = OP_OR;
      w_src1 = w_ui12;
    end else if (in_inst[31:22] == 10'h00F) begin
      w_op   = OP_XOR;
      w_src1 = w_ui12;
    end else if (in_inst[31:25] == 7'h0A) begin
      w_op   = OP_LU12;
      w_src0 = 32'd0;
      w_src1 = w_u20;
    end else if (in_inst[31:25] == 7'h0E) begin
      w_op   = OP_PCAU;
      w_src0 = in_pc;
      w_src1 = w_u20;
    end else begin
      w_legal = 1'b0;
      w_op    = OP_ADD;
      w_src0  = 32'd0;
      w_src1  = 32'd0;
    end
  end

  // Issue slot: flush wins over accept, payload only moves on accept so a
  // stalled slot holds every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_alu_op <= 5'd0;
      r_src0   <= 32'd0;
      r_src1   <= 32'd0;
      r_wb_en  <= 1'b0;
      r_wb_rd  <= 5'd0;
      r_pc     <= 32'd0;
      r_ill    <= 1'b0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (in_ready)
        r_valid <= w_accept && (w_legal || (ILLEGAL_AS_NOP != 0));
      if (w_accept) begin
        r_alu_op <= w_op;
        r_src0   <= w_src0;
        r_src1   <= w_src1;
        r_wb_en  <= w_wb_en;
        r_wb_rd  <= in_inst[4:0];
        r_pc     <= in_pc;
        r_ill    <= !w_legal;
      end
    end
  end

  assign out_valid = r_valid;
  assign alu_op    = r_alu_op;
  assign alu_src0  = r_src0;
  assign alu_src1  = r_src1;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign out_pc    = r_pc;
  assign ill       = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed test-plan sequence followed by random traffic,
// all checked against a mnemonic-level decode model and a one-slot model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc, rf_rdata0, rf_rdata1;

  logic        in_ready, out_valid, wb_en, ill;
  logic [4:0]  rf_raddr0, rf_raddr1, alu_op, wb_rd;
  logic [31:0] alu_src0, alu_src1, out_pc;

  logic        n_in_ready, n_out_valid, n_wb_en, n_ill;
  logic [4:0]  n_raddr0, n_raddr1, n_alu_op, n_wb_rd;
  logic [31:0] n_src0, n_src1, n_pc;

  always #5 clk = ~clk;

  alu_issue_stage #(.ILLEGAL_AS_NOP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .wb_en(wb_en),
    .wb_rd(wb_rd), .out_pc(out_pc), .ill(ill)
  );

  // Drop-illegal variant; always ready downstream, so it accepts every valid.
  alu_issue_stage #(.ILLEGAL_AS_NOP(0)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_raddr0(n_raddr0), .rf_raddr1(n_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .out_valid(n_out_valid), .out_ready(1'b1), .alu_op(n_alu_op),
    .alu_src0(n_src0), .alu_src1(n_src1), .wb_en(n_wb_en),
    .wb_rd(n_wb_rd), .out_pc(n_pc), .ill(n_ill)
  );

  typedef struct packed {
    logic        legal;
    logic [4:0]  op;
    logic [31:0] s0;
    logic [31:0] s1;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] pc;
  } dec_t;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00010, SLT = 5'b00100,
                         SLTU = 5'b00101, AND_ = 5'b01001, OR_ = 5'b01010,
                         XOR_ = 5'b01011, SLL = 5'b01110, SRL = 5'b01111,
                         SRA = 5'b10000, LU12 = 5'b10011, PCAU = 5'b10111;

  int   n_cmp = 0;
  int   n_err = 0;
  logic m_v, m_v0;
  dec_t m_d;

  logic [16:0] RR [10] = '{17'h00020, 17'h00022, 17'h00024, 17'h00025, 17'h00029,
                           17'h0002A, 17'h0002B, 17'h0002E, 17'h0002F, 17'h00030};
  logic [16:0] SH [3]  = '{17'h00081, 17'h00089, 17'h00091};
  logic [9:0]  IM [6]  = '{10'h008, 10'h009, 10'h00A, 10'h00D, 10'h00E, 10'h00F};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction meaning straight from the ISA table, one mnemonic per entry.
  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
    dec_t d;
    logic [31:0] si12, ui12, u20, ui5;
    si12 = {{20{i[21]}}, i[21:10]};
    ui12 = {20'b0, i[21:10]};
    u20  = {i[24:5], 12'b0};
    ui5  = {27'b0, i[14:10]};
    d = '0;
    d.legal = 1'b1; d.rd = i[4:0]; d.pc = pc; d.s0 = a; d.s1 = b;
    case (i[31:15])
      17'h00020: d.op = ADD;
      17'h00022: d.op = SUB;
      17'h00024: d.op = SLT;
      17'h00025: d.op = SLTU;
      17'h00029: d.op = AND_;
      17'h0002A: d.op = OR_;
      17'h0002B: d.op = XOR_;
      17'h0002E: d.op = SLL;
      17'h0002F: d.op = SRL;
      17'h00030: d.op = SRA;
      17'h00081: begin d.op = SLL; d.s1 = ui5; end
      17'h00089: begin d.op = SRL; d.s1 = ui5; end
      17'h00091: begin d.op = SRA; d.s1 = ui5; end
      default: case (i[31:22])
        10'h008: begin d.op = SLT;  d.s1 = si12; end
        10'h009: begin d.op = SLTU; d.s1 = si12; end
        10'h00A: begin d.op = ADD;  d.s1 = si12; end
        10'h00D: begin d.op = AND_; d.s1 = ui12; end
        10'h00E: begin d.op = OR_;  d.s1 = ui12; end
        10'h00F: begin d.op = XOR_; d.s1 = ui12; end
        default: case (i[31:25])
          7'h0A:   begin d.op = LU12; d.s0 = 32'd0; d.s1 = u20; end
          7'h0E:   begin d.op = PCAU; d.s0 = pc;    d.s1 = u20; end
          default: d.legal = 1'b0;
        endcase
      endcase
    endcase
    if (!d.legal) begin d.op = ADD; d.s0 = 32'd0; d.s1 = 32'd0; end
    d.wb = d.legal && (i[4:0] != 5'd0);
    return d;
  endfunction

  // One clock: drive at the falling edge, check combinational outputs,
  // advance the model, then check registered outputs at the next falling edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    dec_t d;
    logic acc;
    rst = r; in_valid = v; in_inst = inst; in_pc = pc;
    rf_rdata0 = a; rf_rdata1 = b; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_v || ordy)});
    chk("rf_raddr0", {27'b0, rf_raddr0}, {27'b0, inst[9:5]});
    chk("rf_raddr1", {27'b0, rf_raddr1}, {27'b0, inst[14:10]});
    d   = ref_dec(inst, pc, a, b);
    acc = v && (!m_v || ordy);
    if (r) begin
      m_v = 1'b0; m_v0 = 1'b0; m_d = '0;
    end else begin
      if (acc) m_d = d;
      if (fl) m_v = 1'b0;
      else if (!m_v || ordy) m_v = acc;
      m_v0 = v && !fl && d.legal;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
    chk("drop_out_valid", {31'b0, n_out_valid}, {31'b0, m_v0});
    if (m_v) begin
      chk("alu_op", {27'b0, alu_op}, {27'b0, m_d.op});
      chk("alu_src0", alu_src0, m_d.s0);
      chk("alu_src1", alu_src1, m_d.s1);
      chk("wb_en", {31'b0, wb_en}, {31'b0, m_d.wb});
      chk("wb_rd", {27'b0, wb_rd}, {27'b0, m_d.rd});
      chk("out_pc", out_pc, m_d.pc);
      chk("ill", {31'b0, ill}, {31'b0, !m_d.legal});
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: return {RR[$urandom_range(0, 9)], w[14:0]};
      1: return {SH[$urandom_range(0, 2)], w[14:0]};
      2: return {IM[$urandom_range(0, 5)], w[21:0]};
      3: return {7'h0A, w[24:0]};
      4: return {7'h0E, w[24:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    m_v = 1'b0; m_v0 = 1'b0; m_d = '0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; rf_rdata0 = '0; rf_rdata1 = '0;
    @(negedge clk);

    // reset, including flush asserted together with reset
    cycle(1, 1, 32'h00100823, 32'h100, 1, 2, 1, 1);
    cycle(1, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    chk("rst_ill", {31'b0, ill}, 32'd0);
    chk("rst_alu_op", {27'b0, alu_op}, 32'd0);
    chk("rst_src0", alu_src0, 32'd0);
    chk("rst_src1", alu_src1, 32'd0);
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 1, 0);

    // add.w r3,r1,r2
    cycle(0, 1, 32'h00100823, 32'h1C000000, 5, 7, 1, 0);
    chk("add_src0", alu_src0, 32'd5);
    chk("add_src1", alu_src1, 32'd7);
    chk("add_wb_rd", {27'b0, wb_rd}, 32'd3);
    // addi.w r4,r1,-1 and ori r4,r1,0xFFF
    cycle(0, 1, 32'h02BFFC24, 32'h1C000004, 9, 9, 1, 0);
    chk("addi_src1", alu_src1, 32'hFFFFFFFF);
    cycle(0, 1, 32'h03BFFC24, 32'h1C000008, 9, 9, 1, 0);
    chk("ori_src1", alu_src1, 32'h00000FFF);
    chk("ori_op", {27'b0, alu_op}, 32'h0A);
    // pcaddu12i r5,1
    cycle(0, 1, 32'h1C000025, 32'h1C000000, 3, 3, 1, 0);
    chk("pcau_op", {27'b0, alu_op}, 32'h17);
    chk("pcau_src0", alu_src0, 32'h1C000000);
    chk("pcau_src1", alu_src1, 32'h00001000);

    // stall three cycles with sub.w waiting, then release
    for (int k = 0; k < 3; k++)
      cycle(0, 1, 32'h00110823, 32'h2000, 11, 4, 0, 0);
    chk("stall_hold_src1", alu_src1, 32'h00001000);
    cycle(0, 1, 32'h00110823, 32'h2000, 11, 4, 1, 0);
    chk("release_op", {27'b0, alu_op}, 32'h02);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 1, 0);

    // flush coincident with accept, then flush of a stalled slot
    cycle(0, 1, 32'h00100823, 32'h3000, 1, 1, 1, 1);
    cycle(0, 1, 32'h00100823, 32'h3004, 1, 1, 1, 0);
    cycle(0, 1, 32'h00100823, 32'h3008, 1, 1, 0, 1);

    // illegal word: issued as nop here, dropped by the other variant
    cycle(0, 1, 32'hFFFFFFFF, 32'h4000, 6, 6, 1, 0);
    chk("ill_flag", {31'b0, ill}, 32'd1);
    chk("ill_wb_en", {31'b0, wb_en}, 32'd0);
    chk("ill_drop_valid", {31'b0, n_out_valid}, 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), gen_inst(),
            $urandom, $urandom, $urandom, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
